// File: rtl/cart_checkout_ctrl.sv
// -----------------------------------------------------------------------------
// cart_checkout_ctrl
//   Session controller for the shopping-cart billing datapath. Captures
//   product-button presses, shares the single price adder between the three
//   products with a round-robin arbiter, sequences the pay/cancel flow and
//   holds the running 8-bit bill.
//
// Ports
//   Clk        in   system clock, all state on rising edge
//   Rst        in   asynchronous active-low reset
//   P1..P3     in   debounced product button levels
//   Pay        in   debounced pay button level
//   Cancel     in   debounced cancel-cart button level
//   Bill       out  [7:0] running bill total (saturates at 255)
//   Item       out  [1:0] product being added (1..3), 0 outside ADD
//   Add_pulse  out  one cycle per price addition
//   Busy       out  requests pending or an add in flight
//   Paid       out  high throughout the PAID hold
//   Overflow   out  sticky: bill saturated during this session
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | empty cart, Bill=0, Pay ignored
// SHOP  | cart has items, waiting for more items or a payment
// ADD   | one-cycle price addition for the granted product
// PAID  | payment taken, Bill frozen for HOLD_CYC cycles
// -----------------------------------------------------------------------------
module cart_checkout_ctrl #(
  parameter logic [7:0]  PRICE1   = 8'd10,
  parameter logic [7:0]  PRICE2   = 8'd20,
  parameter logic [7:0]  PRICE3   = 8'd50,
  parameter int unsigned HOLD_CYC = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       P1,
  input  logic       P2,
  input  logic       P3,
  input  logic       Pay,
  input  logic       Cancel,
  output logic [7:0] Bill,
  output logic [1:0] Item,
  output logic       Add_pulse,
  output logic       Busy,
  output logic       Paid,
  output logic       Overflow
);

  localparam int unsigned CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOP = 2'd1,
    ST_ADD  = 2'd2,
    ST_PAID = 2'd3
  } state_t;

  // Button bit order in btn_*: {Cancel, Pay, P3, P2, P1}
  localparam int B_PAY    = 3;
  localparam int B_CANCEL = 4;

  state_t           state_q, state_d;
  logic [2:0]       pending_q, pending_d;   // bit0 = P1
  logic             pay_req_q, pay_req_d;
  logic [1:0]       rr_q, rr_d;             // 0..2 = P1..P3
  logic [1:0]       grant_q, grant_d;       // product in flight during ADD
  logic [4:0]       btn_q, btn_d;
  logic [7:0]       bill_q, bill_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       item_q, item_d;
  logic             add_pulse_q, add_pulse_d;
  logic             busy_q, busy_d;
  logic             paid_q, paid_d;

  logic [4:0] rise;
  logic [2:0] pend_set;
  logic [2:0] pend_after;
  logic [1:0] rr_after;
  logic [2:0] pick;
  logic [8:0] sum;

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = PRICE1;
      2'd1:    price_of = PRICE2;
      default: price_of = PRICE3;
    endcase
  endfunction

  function automatic logic [1:0] ptr_after(input logic [1:0] g);
    ptr_after = (g == 2'd2) ? 2'd0 : g + 2'd1;
  endfunction

  // Returns {valid, index}. Scans from the lowest priority upwards so the
  // candidate closest to the pointer is the one left standing.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    int         s;
    res = 3'b000;
    for (int k = 2; k >= 0; k--) begin
      s = int'(ptr) + k;
      if (s >= 3) s = s - 3;
      idx = s[1:0];
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    btn_d     = {Cancel, Pay, P3, P2, P1};
    rise      = btn_d & ~btn_q;

    state_d   = state_q;
    pending_d = pending_q;
    pay_req_d = pay_req_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    bill_d    = bill_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;

    pend_set   = pending_q | rise[2:0];
    pend_after = pend_set;
    rr_after   = rr_q;
    sum        = {1'b0, bill_q} + {1'b0, price_of(grant_q)};

    // The add in flight retires at this edge, so the next grant is chosen
    // from what remains with the already-advanced pointer.
    if (state_q == ST_ADD) begin
      pend_after = pend_set & ~(3'b001 << grant_q);
      rr_after   = ptr_after(grant_q);
    end
    pick = rr_pick(pend_after, rr_after);

    if (state_q != ST_PAID && rise[B_CANCEL]) begin
      state_d   = ST_IDLE;
      bill_d    = 8'd0;
      ovf_d     = 1'b0;
      pending_d = 3'b000;
      pay_req_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pending_d = pend_set;
          pay_req_d = 1'b0;
          if (pick[2]) begin
            state_d = ST_ADD;
            grant_d = pick[1:0];
          end
        end
        ST_SHOP: begin
          pending_d = pend_set;
          pay_req_d = pay_req_q | rise[B_PAY];
          if (pick[2]) begin
            state_d = ST_ADD;
            grant_d = pick[1:0];
          end else if (pay_req_d && bill_q != 8'd0) begin
            state_d   = ST_PAID;
            pay_req_d = 1'b0;
            cnt_d     = CNT_LOAD;
          end
        end
        ST_ADD: begin
          bill_d    = sum[8] ? 8'hFF : sum[7:0];
          ovf_d     = ovf_q | sum[8];
          pending_d = pend_after;
          rr_d      = rr_after;
          pay_req_d = pay_req_q | rise[B_PAY];
          if (pick[2]) begin
            grant_d = pick[1:0];
          end else begin
            state_d = ST_SHOP;
          end
        end
        ST_PAID: begin
          pending_d = 3'b000;
          pay_req_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            bill_d  = 8'd0;
            ovf_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          bill_d    = 8'd0;
          ovf_d     = 1'b0;
          pending_d = 3'b000;
          pay_req_d = 1'b0;
        end
      endcase
    end

    add_pulse_d = (state_d == ST_ADD);
    item_d      = add_pulse_d ? grant_d + 2'd1 : 2'd0;
    busy_d      = (pending_d != 3'b000) | add_pulse_d;
    paid_d      = (state_d == ST_PAID);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= 3'b000;
      pay_req_q   <= 1'b0;
      rr_q        <= 2'd0;
      grant_q     <= 2'd0;
      btn_q       <= 5'b00000;
      bill_q      <= 8'd0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      item_q      <= 2'd0;
      add_pulse_q <= 1'b0;
      busy_q      <= 1'b0;
      paid_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pay_req_q   <= pay_req_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      btn_q       <= btn_d;
      bill_q      <= bill_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      item_q      <= item_d;
      add_pulse_q <= add_pulse_d;
      busy_q      <= busy_d;
      paid_q      <= paid_d;
    end
  end

  assign Bill      = bill_q;
  assign Item      = item_q;
  assign Add_pulse = add_pulse_q;
  assign Busy      = busy_q;
  assign Paid      = paid_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_cart_checkout_ctrl.sv
module tb_cart_checkout_ctrl;

  localparam int HOLD = 8;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       P1, P2, P3, Pay, Cancel;
  logic [7:0] Bill;
  logic [1:0] Item;
  logic       Add_pulse, Busy, Paid, Overflow;

  int checks   = 0;
  int failures = 0;
  int n_pulse, n_busy, n_paid;

  always #5 Clk = ~Clk;

  cart_checkout_ctrl #(
    .PRICE1(8'd10), .PRICE2(8'd20), .PRICE3(8'd50), .HOLD_CYC(HOLD)
  ) dut (
    .Clk(Clk), .Rst(Rst), .P1(P1), .P2(P2), .P3(P3), .Pay(Pay), .Cancel(Cancel),
    .Bill(Bill), .Item(Item), .Add_pulse(Add_pulse), .Busy(Busy), .Paid(Paid),
    .Overflow(Overflow)
  );

  // Reference model: cart contents as plain integers and flags.
  int       m_bill;
  bit       m_ovf;
  bit       m_pend [1:3];
  int       m_ptr;        // product searched first, 1..3
  int       m_cur;        // product being added this cycle, 0 = none
  bit       m_shopping;   // at least one item billed this session
  bit       m_payreq;
  int       m_paid_left;  // cycles of payment hold remaining
  bit [4:0] m_prev;

  function automatic int price(input int n);
    case (n)
      1: return 10;
      2: return 20;
      default: return 50;
    endcase
  endfunction

  task automatic model_reset();
    m_bill = 0; m_ovf = 0; m_ptr = 1; m_cur = 0; m_shopping = 0;
    m_payreq = 0; m_paid_left = 0; m_prev = '0;
    for (int i = 1; i <= 3; i++) m_pend[i] = 0;
  endtask

  task automatic model_edge(input bit p1, input bit p2, input bit p3, input bit pay, input bit cn);
    bit [4:0] now, r;
    bit was_shop, active;
    int s, idx;
    now = {cn, pay, p3, p2, p1};
    r = now & ~m_prev;
    m_prev = now;
    if (m_paid_left > 0) begin
      m_paid_left--;
      if (m_paid_left == 0) begin
        m_bill = 0; m_ovf = 0; m_shopping = 0;
      end
    end else if (r[4]) begin
      m_bill = 0; m_ovf = 0; m_payreq = 0; m_cur = 0; m_shopping = 0;
      for (int i = 1; i <= 3; i++) m_pend[i] = 0;
    end else begin
      was_shop = m_shopping && (m_cur == 0);
      active   = m_shopping || (m_cur != 0);
      for (int i = 1; i <= 3; i++) if (r[i-1]) m_pend[i] = 1;
      if (active && r[3]) m_payreq = 1;
      if (m_cur != 0) begin
        s = m_bill + price(m_cur);
        if (s > 255) begin m_bill = 255; m_ovf = 1; end
        else m_bill = s;
        m_pend[m_cur] = 0;
        m_ptr = (m_cur % 3) + 1;
        m_shopping = 1;
      end
      m_cur = 0;
      for (int k = 0; k < 3; k++) begin
        idx = ((m_ptr - 1 + k) % 3) + 1;
        if (m_cur == 0 && m_pend[idx]) m_cur = idx;
      end
      if (m_cur == 0 && was_shop && m_payreq && m_bill != 0) begin
        m_paid_left = HOLD;
        m_payreq = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_outputs(input string ctx);
    bit busy_exp;
    busy_exp = m_pend[1] || m_pend[2] || m_pend[3] || (m_cur != 0);
    chk({ctx, ".bill"},  32'(Bill),      32'(m_bill));
    chk({ctx, ".item"},  32'(Item),      32'(m_cur));
    chk({ctx, ".add"},   32'(Add_pulse), 32'(m_cur != 0));
    chk({ctx, ".busy"},  32'(Busy),      32'(busy_exp));
    chk({ctx, ".paid"},  32'(Paid),      32'(m_paid_left > 0));
    chk({ctx, ".ovf"},   32'(Overflow),  32'(m_ovf));
  endtask

  task automatic step(input bit p1, input bit p2, input bit p3, input bit pay, input bit cn,
                      input string ctx);
    P1 = p1; P2 = p2; P3 = p3; Pay = pay; Cancel = cn;
    @(posedge Clk);
    model_edge(p1, p2, p3, pay, cn);
    #1;
    n_pulse += int'(Add_pulse);
    n_busy  += int'(Busy);
    n_paid  += int'(Paid);
    check_outputs(ctx);
  endtask

  task automatic idle_steps(input int n, input string ctx);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, ctx);
  endtask

  // Assert reset `pre` time units into the current cycle, check outputs
  // before any clock edge, then release on the falling edge.
  task automatic do_reset(input int pre);
    #(pre);
    Rst = 1'b0;
    P1 = 0; P2 = 0; P3 = 0; Pay = 0; Cancel = 0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge Clk);
    Rst = 1'b1;
    n_pulse = 0; n_busy = 0; n_paid = 0;
  endtask

  initial begin
    Rst = 1'b0;
    P1 = 0; P2 = 0; P3 = 0; Pay = 0; Cancel = 0;
    n_pulse = 0; n_busy = 0; n_paid = 0;
    #1;
    do_reset(0);

    // Single P1 held for five cycles counts once.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, "p1_hold");
    idle_steps(2, "p1_rel");
    chk("p1_hold.pulses", 32'(n_pulse), 32'd1);
    chk("p1_hold.bill", 32'(Bill), 32'd10);

    // Simultaneous P1/P2/P3 with pointer at P1.
    do_reset(0);
    step(1, 1, 1, 0, 0, "tri");
    chk("tri.item1", 32'(Item), 32'd1);
    step(0, 0, 0, 0, 0, "tri");
    chk("tri.item2", 32'(Item), 32'd2);
    step(0, 0, 0, 0, 0, "tri");
    chk("tri.item3", 32'(Item), 32'd3);
    idle_steps(2, "tri");
    chk("tri.bill", 32'(Bill), 32'd80);
    chk("tri.busy_cycles", 32'(n_busy), 32'd3);
    chk("tri.pulses", 32'(n_pulse), 32'd3);

    // Six P3 presses saturate, then pay and hold.
    do_reset(0);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 1, 0, 0, "p3x6");
      step(0, 0, 0, 0, 0, "p3x6");
      chk("p3x6.bill", 32'(Bill), (k * 50 > 255) ? 32'd255 : 32'(k * 50));
    end
    chk("p3x6.ovf", 32'(Overflow), 32'd1);
    n_paid = 0;
    step(0, 0, 0, 1, 0, "pay_hold");
    idle_steps(9, "pay_hold");
    chk("pay_hold.paid_cycles", 32'(n_paid), 32'd8);
    chk("pay_hold.bill_after", 32'(Bill), 32'd0);
    chk("pay_hold.ovf_after", 32'(Overflow), 32'd0);

    // Pay together with P2 from Bill=10: item billed first.
    do_reset(0);
    step(1, 0, 0, 0, 0, "defer");
    step(0, 0, 0, 0, 0, "defer");
    step(0, 1, 0, 1, 0, "defer");
    step(0, 0, 0, 0, 0, "defer");
    chk("defer.bill_before_pay", 32'(Bill), 32'd30);
    chk("defer.not_paid_yet", 32'(Paid), 32'd0);
    step(0, 0, 0, 0, 0, "defer");
    chk("defer.paid", 32'(Paid), 32'd1);
    chk("defer.paid_bill", 32'(Bill), 32'd30);
    idle_steps(HOLD + 1, "defer");

    // Pay in IDLE ignored; P1 during PAID ignored.
    do_reset(0);
    step(0, 0, 0, 1, 0, "idle_pay");
    idle_steps(2, "idle_pay");
    chk("idle_pay.paid", 32'(Paid), 32'd0);
    step(1, 0, 0, 0, 0, "paid_p1");
    step(0, 0, 0, 0, 0, "paid_p1");
    step(0, 0, 0, 1, 0, "paid_p1");
    step(1, 0, 0, 0, 0, "paid_p1");
    step(0, 0, 0, 0, 0, "paid_p1");
    chk("paid_p1.bill", 32'(Bill), 32'd10);
    chk("paid_p1.busy", 32'(Busy), 32'd0);
    idle_steps(HOLD, "paid_p1");

    // Cancel during ADD of P3 from Bill=20.
    do_reset(0);
    step(0, 1, 0, 0, 0, "cancel");
    step(0, 0, 0, 0, 0, "cancel");
    step(0, 0, 1, 0, 0, "cancel");
    chk("cancel.in_add", 32'(Item), 32'd3);
    step(0, 0, 0, 0, 1, "cancel");
    chk("cancel.bill", 32'(Bill), 32'd0);
    chk("cancel.busy", 32'(Busy), 32'd0);
    idle_steps(2, "cancel");

    // Asynchronous reset in the middle of PAID.
    step(1, 0, 0, 0, 0, "arst");
    step(0, 0, 0, 0, 0, "arst");
    step(0, 0, 0, 1, 0, "arst");
    step(0, 0, 0, 0, 0, "arst");
    chk("arst.paid_before", 32'(Paid), 32'd1);
    do_reset(2);
    chk("arst.paid_after", 32'(Paid), 32'd0);
    chk("arst.bill_after", 32'(Bill), 32'd0);

    // Randomised sessions against the model.
    for (int i = 0; i < 1500; i++) begin
      bit rp1, rp2, rp3, rpay, rcn;
      rp1  = ($urandom_range(0, 3) == 0);
      rp2  = ($urandom_range(0, 3) == 0);
      rp3  = ($urandom_range(0, 2) == 0);
      rpay = ($urandom_range(0, 7) == 0);
      rcn  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(0, 3));
      step(rp1, rp2, rp3, rpay, rcn, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
